// File: rtl/test_seq_engine_if.sv
// DAC request / ADC sample channel between the test sequencer
// and the analog front-end interface blocks.
interface test_seq_engine_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic [DATA_W-1:0] dac_data;
    logic [CH_W-1:0]   dac_ch;
    logic              dac_valid;
    logic              dac_ready;
    logic [DATA_W-1:0] adc_data;
    logic              adc_valid;

    modport master (
        output dac_data, dac_ch, dac_valid,
        input  dac_ready, adc_data, adc_valid
    );

    modport slave (
        input  dac_data, dac_ch, dac_valid,
        output dac_ready, adc_data, adc_valid
    );
endinterface

// File: rtl/test_seq_engine.sv
// Multi-channel loopback test sequencer: power-up, DAC drive,
// ADC capture with timeout, tolerance compare, error accounting.
module test_seq_engine #(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int ERR_W   = 16,
    parameter int TO_W    = 16,
    parameter int PWR_DLY = 64,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        test_mode,
    input  logic [CNT_W-1:0]  max_cycles,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] tol,
    input  logic [TO_W-1:0]   timeout,
    test_seq_engine_if.master fe,
    output logic              power_en,
    output logic              busy,
    output logic              test_done,
    output logic              aborted,
    output logic [ERR_W-1:0]  error_count,
    output logic [ERR_W-1:0]  timeout_count,
    output logic [CNT_W-1:0]  cycles_done,
    output logic [CH_W-1:0]   first_fail_ch,
    output logic [DATA_W-1:0] first_fail_data
);
    localparam int PW = (PWR_DLY > 1) ? $clog2(PWR_DLY) : 1;

    typedef enum logic [2:0] {
        IDLE, PWR_UP, DRIVE, WAIT_ADC, CHECK, NEXT, DONE
    } state_t;

    state_t state, nstate;

    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  max_q;
    logic [DATA_W-1:0] seed_q;
    logic [DATA_W-1:0] tol_q;
    logic [TO_W-1:0]   to_q;
    logic [PW-1:0]     pwr_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [CH_W-1:0]   ch;
    logic [CNT_W-1:0]  k;
    logic [DATA_W-1:0] adc_q;
    logic              fail_seen;

    logic [DATA_W-1:0] pat;
    logic [DATA_W:0]   a_ext, e_ext, diff;
    logic [CNT_W-1:0]  cyc_inc;
    logic              go, kill, pwr_done, to_hit;
    logic              last_ch, fail, stop;

    assign pat      = seed_q + DATA_W'(k);
    assign a_ext    = {1'b0, adc_q};
    assign e_ext    = {1'b0, ~pat};
    assign diff     = (a_ext >= e_ext) ? a_ext - e_ext
                                       : e_ext - a_ext;
    assign fail     = diff > {1'b0, tol_q};
    assign go       = start && (test_mode != 2'b11);
    assign kill     = abort && (state != IDLE);
    assign pwr_done = pwr_cnt == PW'(PWR_DLY - 1);
    // a zero timeout disables the ADC watchdog
    assign to_hit   = (to_q != '0) && (to_cnt == to_q - 1'b1);
    assign last_ch  = ch == CH_W'(NUM_CH - 1);
    assign cyc_inc  = cycles_done + 1'b1;
    assign stop     = (mode_q == 2'b00) ||
                      ((mode_q == 2'b01) && (cyc_inc >= max_q));

    assign fe.dac_valid = (state == DRIVE);
    assign fe.dac_ch    = ch;
    assign fe.dac_data  = pat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    always_comb begin
        nstate = state;
        if (kill) begin
            nstate = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (go) nstate = PWR_UP;
                PWR_UP:   if (pwr_done) nstate = DRIVE;
                DRIVE:    if (fe.dac_ready) nstate = WAIT_ADC;
                WAIT_ADC: begin
                    if (fe.adc_valid)  nstate = CHECK;
                    else if (to_hit)   nstate = NEXT;
                end
                CHECK:    nstate = NEXT;
                NEXT: begin
                    if (last_ch && stop) nstate = DONE;
                    else                 nstate = DRIVE;
                end
                DONE:     nstate = IDLE;
                default:  nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q          <= '0;
            max_q           <= '0;
            seed_q          <= '0;
            tol_q           <= '0;
            to_q            <= '0;
            pwr_cnt         <= '0;
            to_cnt          <= '0;
            ch              <= '0;
            k               <= '0;
            adc_q           <= '0;
            fail_seen       <= 1'b0;
            power_en        <= 1'b0;
            busy            <= 1'b0;
            test_done       <= 1'b0;
            aborted         <= 1'b0;
            error_count     <= '0;
            timeout_count   <= '0;
            cycles_done     <= '0;
            first_fail_ch   <= '0;
            first_fail_data <= '0;
        end else if (kill) begin
            power_en  <= 1'b0;
            busy      <= 1'b0;
            aborted   <= 1'b1;
            test_done <= 1'b1;
        end else begin
            unique case (state)
                IDLE: if (go) begin
                    mode_q          <= test_mode;
                    max_q           <= max_cycles;
                    seed_q          <= seed;
                    tol_q           <= tol;
                    to_q            <= timeout;
                    error_count     <= '0;
                    timeout_count   <= '0;
                    cycles_done     <= '0;
                    first_fail_ch   <= '0;
                    first_fail_data <= '0;
                    fail_seen       <= 1'b0;
                    test_done       <= 1'b0;
                    aborted         <= 1'b0;
                    power_en        <= 1'b1;
                    busy            <= 1'b1;
                    pwr_cnt         <= '0;
                    ch              <= '0;
                    k               <= '0;
                end
                PWR_UP: pwr_cnt <= pwr_cnt + 1'b1;
                DRIVE:  to_cnt  <= '0;
                WAIT_ADC: begin
                    if (fe.adc_valid) begin
                        adc_q <= fe.adc_data;
                    end else if (to_hit) begin
                        if (!(&timeout_count))
                            timeout_count <= timeout_count + 1'b1;
                        if (!fail_seen) begin
                            fail_seen       <= 1'b1;
                            first_fail_ch   <= ch;
                            first_fail_data <= '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CHECK: if (fail) begin
                    if (!(&error_count))
                        error_count <= error_count + 1'b1;
                    if (!fail_seen) begin
                        fail_seen       <= 1'b1;
                        first_fail_ch   <= ch;
                        first_fail_data <= adc_q;
                    end
                end
                NEXT: begin
                    if (!last_ch) begin
                        ch <= ch + 1'b1;
                    end else begin
                        ch          <= '0;
                        k           <= k + 1'b1;
                        cycles_done <= cyc_inc;
                    end
                end
                DONE: begin
                    test_done <= 1'b1;
                    busy      <= 1'b0;
                    power_en  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_test_seq_engine.sv
// Scoreboard bench for test_seq_engine: directed runs, a DAC
// monitor checking against queued requests, and an ADC loopback model.
module tb_test_seq_engine;
    localparam int DW   = 16;
    localparam int NCH  = 4;
    localparam int CW   = 2;
    localparam int CNTW = 32;
    localparam int ERRW = 4;
    localparam int TOW  = 16;
    localparam int PD   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [1:0]      test_mode = '0;
    logic [CNTW-1:0] max_cycles = '0;
    logic [DW-1:0]   seed = '0;
    logic [DW-1:0]   tol = '0;
    logic [TOW-1:0]  timeout = '0;
    logic            power_en, busy, test_done, aborted;
    logic [ERRW-1:0] error_count, timeout_count;
    logic [CNTW-1:0] cycles_done;
    logic [CW-1:0]   first_fail_ch;
    logic [DW-1:0]   first_fail_data;

    test_seq_engine_if #(.DATA_W(DW), .CH_W(CW)) fe();

    test_seq_engine #(
        .DATA_W(DW), .NUM_CH(NCH), .CNT_W(CNTW),
        .ERR_W(ERRW), .TO_W(TOW), .PWR_DLY(PD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .test_mode(test_mode), .max_cycles(max_cycles),
        .seed(seed), .tol(tol), .timeout(timeout), .fe(fe),
        .power_en(power_en), .busy(busy), .test_done(test_done),
        .aborted(aborted), .error_count(error_count),
        .timeout_count(timeout_count), .cycles_done(cycles_done),
        .first_fail_ch(first_fail_ch),
        .first_fail_data(first_fail_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic [DW-1:0] data;
    } dac_t;

    dac_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hs_cnt = 0;
    int   hs_cyc = 0;
    int   cyc = 0;
    int   adc_dly = 3;
    int   off[NCH];
    bit   silent[NCH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // DAC monitor: request must match queue head while pending
    always @(negedge clk) begin
        if (rst_n && fe.dac_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dac_unexpected: got ch%0d %h required none",
                         fe.dac_ch, fe.dac_data);
            end else begin
                check("dac_ch", fe.dac_ch, exp_q[0].ch);
                check("dac_data", fe.dac_data, exp_q[0].data);
                if (fe.dac_ready) begin
                    void'(exp_q.pop_front());
                    hs_cnt++;
                    hs_cyc = cyc + 1;
                end
            end
        end
    end

    // ADC loopback: returns ~dac_data + off[ch] after adc_dly clocks
    initial begin
        logic [CW-1:0] c;
        logic [DW-1:0] d;
        fe.adc_valid = 1'b0;
        fe.adc_data  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && fe.dac_valid && fe.dac_ready) begin
                c = fe.dac_ch;
                d = fe.dac_data;
                if (!silent[c]) begin
                    @(posedge clk);
                    repeat (adc_dly) @(posedge clk);
                    #1;
                    fe.adc_data  = ~d + DW'(off[c]);
                    fe.adc_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    fe.adc_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic setup(input logic [1:0] m, input int mc,
                         input logic [DW-1:0] s, input logic [DW-1:0] t,
                         input int to);
        test_mode  = m;
        max_cycles = CNTW'(mc);
        seed       = s;
        tol        = t;
        timeout    = TOW'(to);
        hs_cnt     = 0;
        for (int i = 0; i < NCH; i++) begin
            off[i]    = 0;
            silent[i] = 1'b0;
        end
    endtask

    task automatic push_cycle(input logic [DW-1:0] d);
        for (int i = 0; i < NCH; i++)
            exp_q.push_back({CW'(i), d});
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        int n = 0;
        while (!(test_done && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        done_cyc = cyc;
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL run_budget: got %0d cycles required < %0d",
                     n, budget);
        end
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!fe.dac_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL wait_valid: got none in %0d required dac_valid",
                     n);
        end
    endtask

    task automatic wait_hs(input int target, input int budget);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("hs_reached", hs_cnt >= target, 1);
    endtask

    initial begin
        int s, dc;
        fe.dac_ready = 1'b1;
        setup(2'b00, 0, 16'h0000, 16'h0000, 0);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_power_en", power_en, 0);
        check("rst_busy", busy, 0);
        check("rst_test_done", test_done, 0);
        check("rst_dac_valid", fe.dac_valid, 0);
        check("rst_dac_data", fe.dac_data, 0);
        check("rst_err", error_count, 0);
        check("rst_cycles", cycles_done, 0);
        rst_n = 1'b1;

        // single cycle, exact loopback
        setup(2'b00, 0, 16'hAAAA, 16'h0000, 0);
        push_cycle(16'hAAAA);
        pulse_start();
        s = cyc;
        check("t1_power_en_on", power_en, 1);
        check("t1_busy_on", busy, 1);
        wait_valid(100);
        check("t1_pwr_dly", cyc - s, PD);
        wait_done(500, dc);
        check("t1_hs", hs_cnt, 4);
        check("t1_err", error_count, 0);
        check("t1_to", timeout_count, 0);
        check("t1_done", test_done, 1);
        check("t1_cycles", cycles_done, 1);
        check("t1_power_off", power_en, 0);
        check("t1_aborted", aborted, 0);

        // N-cycle with pattern wrap
        setup(2'b01, 3, 16'hFFFE, 16'h0000, 0);
        push_cycle(16'hFFFE);
        push_cycle(16'hFFFF);
        push_cycle(16'h0000);
        pulse_start();
        wait_done(1000, dc);
        check("t2_hs", hs_cnt, 12);
        check("t2_cycles", cycles_done, 3);
        check("t2_err", error_count, 0);
        check("t2_sb_empty", exp_q.size(), 0);

        // tolerance boundary
        setup(2'b00, 0, 16'h1234, 16'h0002, 0);
        off[1] = 2;
        off[2] = -3;
        push_cycle(16'h1234);
        pulse_start();
        wait_done(500, dc);
        check("t3_err", error_count, 1);
        check("t3_ff_ch", first_fail_ch, 2);
        check("t3_ff_data", first_fail_data, 16'hEDC8);

        // ADC timeout on ch3
        setup(2'b00, 0, 16'h0100, 16'h0000, 10);
        silent[3] = 1'b1;
        push_cycle(16'h0100);
        pulse_start();
        wait_done(500, dc);
        check("t4_to", timeout_count, 1);
        check("t4_err", error_count, 0);
        check("t4_ff_ch", first_fail_ch, 3);
        check("t4_ff_data", first_fail_data, 0);
        check("t4_hs", hs_cnt, 4);
        check("t4_to_latency", dc - hs_cyc, 12);
        check("t4_cycles", cycles_done, 1);

        // sample on the timeout clock is accepted
        setup(2'b00, 0, 16'h0200, 16'h0000, 10);
        adc_dly = 9;
        push_cycle(16'h0200);
        pulse_start();
        wait_done(600, dc);
        check("t4b_to", timeout_count, 0);
        check("t4b_err", error_count, 0);
        adc_dly = 3;

        // free-run, back-pressure, abort in WAIT_ADC
        setup(2'b10, 0, 16'h0500, 16'h0000, 0);
        adc_dly = 20;
        fe.dac_ready = 1'b0;
        exp_q.push_back({CW'(0), 16'h0500});
        pulse_start();
        wait_valid(100);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1 fe.dac_ready = 1'b1;
        wait_hs(1, 20);
        repeat (4) @(negedge clk);
        check("t5_busy_pre", busy, 1);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1;
        check("t5_busy", busy, 0);
        check("t5_power_en", power_en, 0);
        check("t5_aborted", aborted, 1);
        check("t5_done", test_done, 1);
        check("t5_dac_valid", fe.dac_valid, 0);
        check("t5_cycles", cycles_done, 0);
        abort = 1'b0;
        repeat (30) @(posedge clk);
        adc_dly = 3;

        // error saturation, start ignored while busy
        setup(2'b01, 5, 16'h4000, 16'h0000, 0);
        for (int i = 0; i < NCH; i++) off[i] = 1;
        for (int j = 0; j < 5; j++) push_cycle(16'h4000 + DW'(j));
        pulse_start();
        wait_hs(6, 200);
        test_mode = 2'b00;
        seed = 16'h0000;
        pulse_start();
        wait_done(2000, dc);
        check("t6_err_sat", error_count, 4'hF);
        check("t6_cycles", cycles_done, 5);
        check("t6_hs", hs_cnt, 20);
        check("t6_ff_ch", first_fail_ch, 0);
        check("t6_ff_data", first_fail_data, 16'hC000);
        check("t6_aborted", aborted, 0);

        // reserved mode start ignored, status held
        test_mode = 2'b11;
        pulse_start();
        repeat (3) @(negedge clk);
        check("t6_m11_busy", busy, 0);
        check("t6_m11_done", test_done, 1);
        check("t6_m11_err", error_count, 4'hF);
        check("t6_m11_pwr", power_en, 0);

        // async reset mid-run
        setup(2'b10, 0, 16'h0000, 16'h0000, 0);
        pulse_start();
        repeat (3) @(negedge clk);
        check("t7_power_pre", power_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_power_en", power_en, 0);
        check("t7_busy", busy, 0);
        check("t7_done", test_done, 0);
        check("t7_dac_valid", fe.dac_valid, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("t7_sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/test_seq_engine.md
Name: test_seq_engine

Overview:
- Parametrised multi-channel stimulus/response test sequencer for mixed-signal loopback test.
- Sequences: power-up, DAC pattern drive per channel, ADC capture with timeout, tolerance compare, error accounting.
- Supports single, N-cycle and free-running modes.
- Sits between the test-control register block (config/status) and the DAC/ADC interface blocks.

Parameters:
- DATA_W, 16, DAC/ADC sample width
- NUM_CH, 4, channels tested per cycle (1..16)
- CNT_W, 32, cycle counter width
- ERR_W, 16, error counter width (saturating)
- TO_W, 16, ADC timeout counter width
- PWR_DLY, 64, clocks from power_en rise to first DAC drive

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- start, input, 1, one-cycle pulse; starts a run when idle
- abort, input, 1, level; terminates the run
- test_mode, input, 2, 00 single cycle, 01 max_cycles cycles, 10 free-run, 11 reserved
- max_cycles, input, CNT_W, cycle count for mode 01
- seed, input, DATA_W, base pattern
- tol, input, DATA_W, allowed absolute deviation
- timeout, input, TO_W, clocks to wait for adc_valid
- dac_data, output, DATA_W, DAC code
- dac_ch, output, log2(NUM_CH) (min 1), target channel
- dac_valid, output, 1, DAC request
- dac_ready, input, 1, DAC accept
- adc_data, input, DATA_W, ADC sample
- adc_valid, input, 1, sample strobe
- power_en, output, 1, DUT supply enable
- busy, output, 1, run in progress
- test_done, output, 1, sticky run-complete
- aborted, output, 1, sticky: run ended by abort
- error_count, output, ERR_W, compare failures
- timeout_count, output, ERR_W, ADC timeouts
- cycles_done, output, CNT_W, completed cycles
- first_fail_ch, output, log2(NUM_CH), channel of first failure
- first_fail_data, output, DATA_W, ADC data of first failure (0 if timeout)

Behaviour:
- Reset: all outputs 0, state IDLE.
- States: IDLE, PWR_UP, DRIVE, WAIT_ADC, CHECK, NEXT, DONE.
- IDLE, start=1 with test_mode!=11:
  - clear counters, first_fail_*, test_done, aborted
  - power_en<=1, busy<=1, go to PWR_UP
  - start is ignored when test_mode=11 or when not IDLE.
- PWR_UP: wait PWR_DLY clocks, then DRIVE with ch=0, k=0.
- DRIVE:
  - dac_valid=1, dac_ch=ch, dac_data=(seed+k) mod 2^DATA_W
  - dac_data/dac_ch are held stable until dac_ready
  - on the dac_valid&dac_ready cycle: drop dac_valid, clear the timeout counter, go to WAIT_ADC.
- WAIT_ADC:
  - adc_valid: register adc_data, go to CHECK.
  - timeout clocks elapsed without adc_valid: timeout_count+1 (counts as failure for first_fail_*, data 0), go to NEXT.
  - adc_valid arriving on the timeout clock counts as valid.
  - timeout=0 means wait forever.
- CHECK (1 clk):
  - expected = ~dac_data
  - fail if |adc - expected| > tol; difference computed unsigned in DATA_W+1 bits
  - fail: error_count+1
  - first_fail_* captured only when no earlier failure/timeout in the run.
- NEXT:
  - ch<NUM_CH-1: ch+1, go to DRIVE.
  - otherwise: ch=0, k+1, cycles_done+1, then:
    - mode 00: go to DONE.
    - mode 01: DONE if cycles_done+1 >= max_cycles, else DRIVE.
    - mode 10: DRIVE; k wraps mod 2^CNT_W, cycles_done wraps.
- max_cycles=0 in mode 01: one cycle is run (treated as 1).
- DONE: test_done<=1, busy<=0, power_en<=0, go to IDLE; status is held until the next start.
- abort (any state except IDLE):
  - next clock: dac_valid<=0, power_en<=0, busy<=0, aborted<=1, test_done<=1, to IDLE
  - a pending DAC handshake is dropped; counters are kept.
- error_count and timeout_count saturate at all-ones.
- test_mode, max_cycles, seed, tol and timeout are sampled at start and held for the run.
- Async reset mid-run: immediate return to reset values, power_en low.

Test Plan:
- NUM_CH=4, mode 00, seed=16'hAAAA, tol=0, ADC model returns ~dac_data after 3 clks -> 4 DAC handshakes with data AAAA on ch0..3; error_count=0; test_done=1; cycles_done=1; power_en low.
- Mode 01, max_cycles=3, seed=16'hFFFE -> dac_data FFFE, FFFF, 0000 (wrap); cycles_done=3; 12 handshakes total.
- tol=2, ADC returns expected+2 on ch1 and expected-3 on ch2 -> error_count=1; first_fail_ch=2; first_fail_data=expected-3.
- timeout=10, ADC silent on ch3 -> timeout_count=1 after 10 clks in WAIT_ADC; first_fail_data=0; sequence continues to completion.
- Mode 10, dac_ready held low for 5 clks -> dac_data stable throughout; abort asserted mid-WAIT_ADC -> next clock busy=0, power_en=0, aborted=1, test_done=1.
- error_count at 16'hFFFF plus another failure -> stays FFFF; start pulsed while busy -> ignored.
